motor_cmd_sequencer: RTL and testbench

//  Command front-end for the NCH-channel PWM/H-bridge motor datapath. Accepts per-channel
//  {direction, duty} commands, then ramps each channel's PWM compare value toward its target
//  one step per ramp tick. On a direction change it ramps to zero, holds a dead-time, flips

---
 rtl/motor_cmd_sequencer_pkg.sv | 25 ++
 rtl/motor_cmd_sequencer_ch_fsm.sv | 129 ++++++++++++
 rtl/motor_cmd_sequencer.sv | 74 +++++++
 tb/tb_motor_cmd_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor_cmd_sequencer_pkg
//  Description : Shared state encodings and default sizing for the motor
//                command sequencer and its per-channel ramp FSM.
//  Revision    : 1.0  initial release
// ============================================================================
package motor_cmd_sequencer_pkg;

    localparam int DEF_NCH        = 8;
    localparam int DEF_CTR_LEN    = 3;
    localparam int DEF_RAMP_DIV   = 1024;
    localparam int DEF_DEAD_TICKS = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    // Counter must hold the full DEAD_TICKS load value.
    function automatic int dead_cnt_width(input int ticks);
        return (ticks < 2) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_cmd_sequencer_ch_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : motor_ch_fsm
//  Description : One motor channel: holds the commanded target and ramps the
//                PWM compare value toward it, inserting a dead-time at duty 0
//                before any H-bridge direction flip.
//  Revision    : 1.0  initial release
// ============================================================================
module motor_ch_fsm
    import motor_cmd_sequencer_pkg::*;
#(
    parameter int CTR_LEN    = DEF_CTR_LEN,
    parameter int DEAD_TICKS = DEF_DEAD_TICKS
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               tick,
    input  logic               wr_en,
    input  logic               wr_dir,
    input  logic [CTR_LEN-1:0] wr_duty,
    input  logic               estop,
    output logic [CTR_LEN-1:0] duty,
    output logic               dir,
    output logic               busy
);

    localparam int                  c_DEAD_W    = dead_cnt_width(DEAD_TICKS);
    localparam logic [c_DEAD_W-1:0] c_DEAD_LOAD = c_DEAD_W'(DEAD_TICKS);
    localparam logic [c_DEAD_W-1:0] c_DEAD_ONE  = c_DEAD_W'(1);
    localparam logic [CTR_LEN-1:0]  c_DUTY_ONE  = CTR_LEN'(1);

    logic [1:0]          r_state;
    logic [CTR_LEN-1:0]  r_duty;
    logic                r_dir;
    logic [c_DEAD_W-1:0] r_dead_cnt;
    logic                r_tgt_dir;
    logic [CTR_LEN-1:0]  r_tgt_duty;

    logic                w_dir_mismatch;
    logic [CTR_LEN-1:0]  w_duty_up;
    logic [CTR_LEN-1:0]  w_duty_dn;

    assign w_dir_mismatch = (r_dir != r_tgt_dir);
    assign w_duty_up      = r_duty + 1'b1;
    assign w_duty_dn      = r_duty - 1'b1;

    // Tick logic reads the registered targets, so a write landing on the same
    // edge only takes effect from the following tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_duty     <= '0;
            r_dir      <= 1'b0;
            r_dead_cnt <= '0;
            r_tgt_dir  <= 1'b0;
            r_tgt_duty <= '0;
        end else if (estop) begin
            r_duty     <= '0;
            r_tgt_duty <= '0;
            if (r_duty != '0) begin
                r_state    <= ST_DEAD;
                r_dead_cnt <= c_DEAD_LOAD;
            end
        end else begin
            if (tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_dir_mismatch) begin
                            if (r_duty != '0) begin
                                r_state <= ST_RAMP;
                            end else begin
                                r_state    <= ST_DEAD;
                                r_dead_cnt <= c_DEAD_LOAD;
                            end
                        end else if (r_duty != r_tgt_duty) begin
                            r_state <= ST_RAMP;
                        end
                    end
                    ST_RAMP: begin
                        if (w_dir_mismatch) begin
                            if (r_duty <= c_DUTY_ONE) begin
                                r_duty     <= '0;
                                r_state    <= ST_DEAD;
                                r_dead_cnt <= c_DEAD_LOAD;
                            end else begin
                                r_duty <= w_duty_dn;
                            end
                        end else if (r_duty < r_tgt_duty) begin
                            r_duty <= w_duty_up;
                            if (w_duty_up == r_tgt_duty) begin
                                r_state <= ST_IDLE;
                            end
                        end else if (r_duty > r_tgt_duty) begin
                            r_duty <= w_duty_dn;
                            if (w_duty_dn == r_tgt_duty) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DEAD: begin
                        // Dead-time always runs to completion before the flip.
                        if (r_dead_cnt <= c_DEAD_ONE) begin
                            r_dead_cnt <= '0;
                            r_dir      <= r_tgt_dir;
                            r_state    <= (r_tgt_duty != '0) ? ST_RAMP : ST_IDLE;
                        end else begin
                            r_dead_cnt <= r_dead_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
            if (wr_en) begin
                r_tgt_dir  <= wr_dir;
                r_tgt_duty <= wr_duty;
            end
        end
    end

    assign duty = r_duty;
    assign dir  = r_dir;
    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : motor_cmd_sequencer
//  Description : Command front-end for the multi-channel PWM/H-bridge motor
//                datapath: ramp prescaler, command decode and output packing.
//  Revision    : 1.0  initial release
// ============================================================================
module motor_cmd_sequencer
    import motor_cmd_sequencer_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int CTR_LEN    = DEF_CTR_LEN,
    parameter int RAMP_DIV   = DEF_RAMP_DIV,
    parameter int DEAD_TICKS = DEF_DEAD_TICKS
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(NCH)-1:0]   cmd_ch,
    input  logic                     cmd_dir,
    input  logic [CTR_LEN-1:0]       cmd_duty,
    input  logic                     estop,
    output logic [NCH*CTR_LEN-1:0]   duty_out,
    output logic [NCH-1:0]           dir_out,
    output logic [NCH-1:0]           busy
);

    localparam int                c_CH_W    = $clog2(NCH);
    localparam int                c_PS_W    = $clog2(RAMP_DIV);
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(RAMP_DIV - 1);

    logic [c_PS_W-1:0] r_presc;
    logic              w_tick;
    logic              w_accept;
    logic [NCH-1:0]    w_wr_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
        end else if (r_presc == c_PS_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick    = (r_presc == c_PS_LAST);
    assign cmd_ready = ~estop;
    assign w_accept  = cmd_valid & ~estop;

    // Out-of-range channel numbers match no decoder bit and are silently dropped.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_wr_en[gi] = w_accept & (cmd_ch == c_CH_W'(gi));

        motor_ch_fsm #(
            .CTR_LEN    (CTR_LEN),
            .DEAD_TICKS (DEAD_TICKS)
        ) u_ch_fsm (
            .clk     (clk),
            .rstn    (rstn),
            .tick    (w_tick),
            .wr_en   (w_wr_en[gi]),
            .wr_dir  (cmd_dir),
            .wr_duty (cmd_duty),
            .estop   (estop),
            .duty    (duty_out[gi*CTR_LEN +: CTR_LEN]),
            .dir     (dir_out[gi]),
            .busy    (busy[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_cmd_sequencer
//  Description : Self-checking bench for motor_cmd_sequencer with a
//                tick-level behavioural model of the channel ramp rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_motor_cmd_sequencer;

    localparam int NCH        = 8;
    localparam int CTR_LEN    = 3;
    localparam int RAMP_DIV   = 4;
    localparam int DEAD_TICKS = 2;

    logic                   clk       = 1'b0;
    logic                   rstn      = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic [2:0]             cmd_ch    = '0;
    logic                   cmd_dir   = 1'b0;
    logic [CTR_LEN-1:0]     cmd_duty  = '0;
    logic                   estop     = 1'b0;
    logic                   cmd_ready;
    logic [NCH*CTR_LEN-1:0] duty_out;
    logic [NCH-1:0]         dir_out;
    logic [NCH-1:0]         busy;

    int checks = 0;
    int errors = 0;

    motor_cmd_sequencer #(
        .NCH        (NCH),
        .CTR_LEN    (CTR_LEN),
        .RAMP_DIV   (RAMP_DIV),
        .DEAD_TICKS (DEAD_TICKS)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_dir   (cmd_dir),
        .cmd_duty  (cmd_duty),
        .estop     (estop),
        .duty_out  (duty_out),
        .dir_out   (dir_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 settled, 1 moving, 2 waiting out dead-time.
    int m_cnt;
    bit m_tick;
    int m_duty[NCH];
    int m_dir[NCH];
    int m_tdir[NCH];
    int m_tduty[NCH];
    int m_phase[NCH];
    int m_wait[NCH];

    function automatic void model_step(int c);
        if (m_phase[c] == 0) begin
            if (m_dir[c] != m_tdir[c]) begin
                if (m_duty[c] > 0) m_phase[c] = 1;
                else begin m_phase[c] = 2; m_wait[c] = DEAD_TICKS; end
            end else if (m_duty[c] != m_tduty[c]) m_phase[c] = 1;
        end else if (m_phase[c] == 1) begin
            if (m_dir[c] != m_tdir[c]) begin
                m_duty[c] = (m_duty[c] > 0) ? m_duty[c] - 1 : 0;
                if (m_duty[c] == 0) begin m_phase[c] = 2; m_wait[c] = DEAD_TICKS; end
            end else begin
                if (m_duty[c] < m_tduty[c]) m_duty[c]++;
                else if (m_duty[c] > m_tduty[c]) m_duty[c]--;
                if (m_duty[c] == m_tduty[c]) m_phase[c] = 0;
            end
        end else begin
            m_wait[c]--;
            if (m_wait[c] <= 0) begin
                m_dir[c]   = m_tdir[c];
                m_phase[c] = (m_tduty[c] != 0) ? 1 : 0;
            end
        end
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt = 0;
            for (int c = 0; c < NCH; c++) begin
                m_duty[c] = 0; m_dir[c] = 0; m_tdir[c] = 0;
                m_tduty[c] = 0; m_phase[c] = 0; m_wait[c] = 0;
            end
        end else begin
            m_tick = (m_cnt == RAMP_DIV - 1);
            m_cnt  = (m_cnt + 1) % RAMP_DIV;
            if (estop) begin
                for (int c = 0; c < NCH; c++) begin
                    if (m_duty[c] > 0) begin m_phase[c] = 2; m_wait[c] = DEAD_TICKS; end
                    m_duty[c]  = 0;
                    m_tduty[c] = 0;
                end
            end else begin
                if (m_tick) for (int c = 0; c < NCH; c++) model_step(c);
                if (cmd_valid) begin
                    m_tdir[cmd_ch]  = int'(cmd_dir);
                    m_tduty[cmd_ch] = int'(cmd_duty);
                end
            end
        end
    end

    function automatic logic [NCH*CTR_LEN-1:0] exp_duty();
        logic [NCH*CTR_LEN-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*CTR_LEN +: CTR_LEN] = CTR_LEN'(m_duty[c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_dir();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (m_dir[c] != 0);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (m_phase[c] != 0);
        return v;
    endfunction

    function automatic bit model_idle();
        for (int c = 0; c < NCH; c++) if (m_phase[c] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ch_duty(int c);
        return int'(duty_out[c*CTR_LEN +: CTR_LEN]);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int ch, input int d, input int du);
        cmd_valid = 1'b1;
        cmd_ch    = 3'(ch);
        cmd_dir   = 1'(d);
        cmd_duty  = 3'(du);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cyc(2);
        checks++; if (duty_out !== '0) begin errors++; $display("FAIL reset_duty got %h want 0", duty_out); end
        checks++; if (dir_out !== '0) begin errors++; $display("FAIL reset_dir got %h want 0", dir_out); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        rstn = 1'b1;
        cyc(1);
    endtask

    task automatic test_ramp_up();
        int prev, last_chg, cur, n_chg;
        bit done;
        prev = 0; last_chg = -1; n_chg = 0; done = 1'b0;
        send(2, 0, 5);
        for (int k = 0; k < 120 && !done; k++) begin
            @(negedge clk);
            checks++;
            if ({duty_out, dir_out, busy} !== {exp_duty(), exp_dir(), exp_busy()}) begin
                errors++;
                $display("FAIL ramp_up_model k=%0d got %h/%h/%h want %h/%h/%h", k, duty_out, dir_out, busy, exp_duty(), exp_dir(), exp_busy());
            end
            cur = ch_duty(2);
            if (cur != prev) begin
                checks++; if (cur != prev + 1) begin errors++; $display("FAIL ramp_up_step got %0d want %0d", cur, prev + 1); end
                if (last_chg >= 0) begin
                    checks++; if (k - last_chg != RAMP_DIV) begin errors++; $display("FAIL ramp_up_spacing got %0d want %0d", k - last_chg, RAMP_DIV); end
                end
                checks++; if (busy[2] !== (cur != 5)) begin errors++; $display("FAIL ramp_up_busy duty=%0d got %b want %b", cur, busy[2], cur != 5); end
                last_chg = k; prev = cur; n_chg++;
                if (cur == 5) done = 1'b1;
            end
        end
        checks++; if (!done || n_chg != 5) begin errors++; $display("FAIL ramp_up_done got steps=%0d want 5", n_chg); end
        checks++; if ((duty_out & ~(24'h7 << 6)) !== '0) begin errors++; $display("FAIL ramp_up_others got %h want 0", duty_out & ~(24'h7 << 6)); end
    endtask

    task automatic test_reversal();
        int obs[$];
        int exp_q[$];
        int pd, pr, cd, cr, zc;
        exp_q = '{4, 3, 2, 1, 0, -1, 1, 2, 3};
        pd = 5; pr = 0; zc = 0;
        send(2, 1, 3);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            checks++;
            if ({duty_out, dir_out, busy} !== {exp_duty(), exp_dir(), exp_busy()}) begin
                errors++;
                $display("FAIL reversal_model k=%0d got %h/%h/%h want %h/%h/%h", k, duty_out, dir_out, busy, exp_duty(), exp_dir(), exp_busy());
            end
            cd = ch_duty(2);
            cr = int'(dir_out[2]);
            if (cr != pr) begin
                obs.push_back(-1);
                checks++;
                if (pd != 0 || cd != 0 || zc < DEAD_TICKS * RAMP_DIV) begin
                    errors++;
                    $display("FAIL reversal_flip_guard got prev=%0d now=%0d zero_cyc=%0d want 0/0/>=%0d", pd, cd, zc, DEAD_TICKS * RAMP_DIV);
                end
                pr = cr;
            end
            if (cd != pd) begin obs.push_back(cd); pd = cd; end
            if (cd == 0) zc++; else zc = 0;
            if (cr == 1 && cd == 3 && m_phase[2] == 0) break;
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL reversal_len got %0d want %0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (obs[i] != exp_q[i]) begin errors++; $display("FAIL reversal_seq[%0d] got %0d want %0d", i, obs[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_estop();
        send(0, 0, 6);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++; if (duty_out !== exp_duty()) begin errors++; $display("FAIL estop_pre k=%0d got %h want %h", k, duty_out, exp_duty()); end
            if (m_phase[0] == 0 && m_duty[0] == 6) break;
        end
        checks++; if (ch_duty(0) != 6) begin errors++; $display("FAIL estop_ch0_level got %0d want 6", ch_duty(0)); end
        send(5, 0, 7);
        cyc(9);
        estop = 1'b1; cmd_valid = 1'b1; cmd_ch = 3'd3; cmd_dir = 1'b1; cmd_duty = 3'd5;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL estop_ready got %b want 0", cmd_ready); end
        @(negedge clk);
        estop = 1'b0; cmd_valid = 1'b0;
        checks++; if (duty_out !== '0) begin errors++; $display("FAIL estop_duty got %h want 0", duty_out); end
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL estop_ch0_dead got %b want 1", busy[0]); end
        checks++; if ({dir_out, busy} !== {exp_dir(), exp_busy()}) begin errors++; $display("FAIL estop_state got %h/%h want %h/%h", dir_out, busy, exp_dir(), exp_busy()); end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({duty_out, dir_out, busy} !== {exp_duty(), exp_dir(), exp_busy()}) begin
                errors++; $display("FAIL estop_settle k=%0d got %h/%h/%h want %h/%h/%h", k, duty_out, dir_out, busy, exp_duty(), exp_dir(), exp_busy());
            end
            if (model_idle()) break;
        end
        checks++; if (duty_out !== '0 || busy !== '0) begin errors++; $display("FAIL estop_quiet got %h/%h want 0/0", duty_out, busy); end
        checks++; if (dir_out[3] !== 1'b0) begin errors++; $display("FAIL estop_cmd_ignored got %b want 0", dir_out[3]); end
        send(0, 0, 2);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++; if (ch_duty(0) > 2 || duty_out !== exp_duty()) begin errors++; $display("FAIL estop_resume k=%0d got %h want %h", k, duty_out, exp_duty()); end
            if (m_phase[0] == 0 && m_duty[0] == 2) break;
        end
        checks++; if (ch_duty(0) != 2 || busy[0] !== 1'b0) begin errors++; $display("FAIL estop_resume_end got %0d/%b want 2/0", ch_duty(0), busy[0]); end
    endtask

    task automatic test_retarget();
        int obs[$];
        int pd, cd;
        send(7, 0, 7);
        for (int k = 0; k < 200 && ch_duty(7) != 4; k++) @(negedge clk);
        checks++; if (ch_duty(7) != 4) begin errors++; $display("FAIL retarget_a_reach got %0d want 4", ch_duty(7)); end
        send(7, 0, 2);
        pd = ch_duty(7);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cd = ch_duty(7);
            if (cd != pd) begin obs.push_back(cd); pd = cd; end
            if (m_phase[7] == 0) break;
        end
        checks++; if (obs.size() != 2 || obs[0] != 3 || obs[1] != 2) begin errors++; $display("FAIL retarget_a_seq got n=%0d last=%0d want 3,2", obs.size(), pd); end
        checks++; if (busy[7] !== 1'b0) begin errors++; $display("FAIL retarget_a_idle got %b want 0", busy[7]); end

        obs.delete();
        send(6, 0, 7);
        for (int k = 0; k < 200 && ch_duty(6) != 4; k++) @(negedge clk);
        for (int k = 0; k < 8 && m_cnt != RAMP_DIV - 1; k++) @(negedge clk);
        send(6, 0, 2);
        checks++; if (ch_duty(6) != 5) begin errors++; $display("FAIL retarget_b_old_target got %0d want 5", ch_duty(6)); end
        pd = 5;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++; if (duty_out !== exp_duty()) begin errors++; $display("FAIL retarget_b_model k=%0d got %h want %h", k, duty_out, exp_duty()); end
            cd = ch_duty(6);
            if (cd != pd) begin obs.push_back(cd); pd = cd; end
            if (m_phase[6] == 0) break;
        end
        checks++; if (obs.size() != 3 || obs[0] != 4 || obs[2] != 2) begin errors++; $display("FAIL retarget_b_seq got n=%0d last=%0d want 4,3,2", obs.size(), pd); end
    endtask

    task automatic test_dead_only();
        int bh;
        bh = 0;
        send(1, 1, 0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++; if ({dir_out, busy} !== {exp_dir(), exp_busy()}) begin errors++; $display("FAIL dead_only_model k=%0d got %h/%h want %h/%h", k, dir_out, busy, exp_dir(), exp_busy()); end
            checks++; if (ch_duty(1) != 0) begin errors++; $display("FAIL dead_only_duty got %0d want 0", ch_duty(1)); end
            if (busy[1]) bh++;
            if (dir_out[1]) break;
        end
        checks++; if (dir_out[1] !== 1'b1) begin errors++; $display("FAIL dead_only_dir got %b want 1", dir_out[1]); end
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL dead_only_idle got %b want 0", busy[1]); end
        checks++; if (bh != DEAD_TICKS * RAMP_DIV) begin errors++; $display("FAIL dead_only_busy_len got %0d want %0d", bh, DEAD_TICKS * RAMP_DIV); end
    endtask

    task automatic test_async_reset();
        send(4, 0, 6);
        for (int k = 0; k < 100 && m_duty[4] != 3; k++) @(negedge clk);
        checks++; if (duty_out !== exp_duty()) begin errors++; $display("FAIL async_pre got %h want %h", duty_out, exp_duty()); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (duty_out !== '0) begin errors++; $display("FAIL async_duty got %h want 0", duty_out); end
        checks++; if (dir_out !== '0) begin errors++; $display("FAIL async_dir got %h want 0", dir_out); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL async_busy got %h want 0", busy); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b want 1", cmd_ready); end
        cyc(2);
    endtask

    task automatic test_random();
        int pdir[NCH];
        int pduty[NCH];
        int zt[NCH];
        int est_left, d;
        bit tk;
        for (int c = 0; c < NCH; c++) begin
            pdir[c] = int'(dir_out[c]); pduty[c] = ch_duty(c); zt[c] = 0;
        end
        est_left = 0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            checks++;
            if ({duty_out, dir_out, busy} !== {exp_duty(), exp_dir(), exp_busy()}) begin
                errors++; $display("FAIL random_model k=%0d got %h/%h/%h want %h/%h/%h", k, duty_out, dir_out, busy, exp_duty(), exp_dir(), exp_busy());
            end
            checks++; if (cmd_ready !== ~estop) begin errors++; $display("FAIL random_ready got %b want %b", cmd_ready, ~estop); end
            tk = (m_cnt == 0);
            for (int c = 0; c < NCH; c++) begin
                d = ch_duty(c);
                if (d != 0) zt[c] = 0;
                else if (tk && pduty[c] == 0) zt[c]++;
                if (int'(dir_out[c]) != pdir[c]) begin
                    checks++;
                    if (pduty[c] != 0 || d != 0 || zt[c] < DEAD_TICKS) begin
                        errors++; $display("FAIL random_flip_guard ch=%0d got prev=%0d now=%0d zero_ticks=%0d want 0/0/>=%0d", c, pduty[c], d, zt[c], DEAD_TICKS);
                    end
                end
                pdir[c] = int'(dir_out[c]); pduty[c] = d;
            end
            if (est_left > 0) est_left--;
            else if ($urandom_range(0, 79) == 0) est_left = $urandom_range(1, 3);
            estop     = (est_left > 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_ch    = 3'($urandom_range(0, 7));
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_duty  = 3'($urandom_range(0, 7));
        end
        estop = 1'b0; cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reversal();
        test_estop();
        test_retarget();
        test_dead_only();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
